// File: rtl/exec_unit_mc_pkg.sv
// Shared types for the multi-cycle execute unit: opcodes, branch
// conditions, FSM states, NZCV bit positions and the condition evaluator.
package exe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_ORR  = 4'd3,
    OP_EOR  = 4'd4,
    OP_MOV  = 4'd5,
    OP_MOVT = 4'd6,
    OP_CLR  = 4'd7,
    OP_SET  = 4'd8,
    OP_LSL  = 4'd9,
    OP_LSR  = 4'd10,
    OP_MOVF = 4'd11,
    OP_MUL  = 4'd12,
    OP_LD   = 4'd13,
    OP_ST   = 4'd14,
    OP_BR   = 4'd15
  } op_e;

  typedef enum logic [3:0] {
    C_EQ = 4'd0,
    C_NE = 4'd1,
    C_CS = 4'd2,
    C_CC = 4'd3,
    C_MI = 4'd4,
    C_PL = 4'd5,
    C_VS = 4'd6,
    C_VC = 4'd7,
    C_HI = 4'd8,
    C_LS = 4'd9,
    C_GE = 4'd10,
    C_LT = 4'd11,
    C_GT = 4'd12,
    C_LE = 4'd13,
    C_AL = 4'd14
  } cond_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL      = 2'd1,
    S_MEM_REQ  = 2'd2,
    S_MEM_WAIT = 2'd3
  } state_e;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  // ARM-style condition check against an NZCV vector; code 15 is never taken.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    n    = nzcv[N_BIT];
    z    = nzcv[Z_BIT];
    c    = nzcv[C_BIT];
    v    = nzcv[V_BIT];
    pass = 1'b0;
    case (cond)
      C_EQ:    pass = z;
      C_NE:    pass = !z;
      C_CS:    pass = c;
      C_CC:    pass = !c;
      C_MI:    pass = n;
      C_PL:    pass = !n;
      C_VS:    pass = v;
      C_VC:    pass = !v;
      C_HI:    pass = c && !z;
      C_LS:    pass = !c || z;
      C_GE:    pass = (n == v);
      C_LT:    pass = (n != v);
      C_GT:    pass = !z && (n == v);
      C_LE:    pass = z || (n != v);
      C_AL:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/exec_unit_mc_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// done_o pulses in the last busy cycle; product_o is valid in that cycle
// (low DATA_W bits of a_i * b_i).
module exec_mul_iter
  import exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] acc_step;

  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == LAST);
  assign product_o = acc_step;

  // Load operands on start, otherwise add-and-shift while busy.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  // Control state: reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath registers carry no reset; they are reloaded on every start.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle handshaked execute stage: single-cycle ALU/shift/branch ops,
// iterative MUL, and a request/grant/response memory port for LD/ST.
// Owns the NZCV flags register, written only when a result is captured.
module exec_unit_mc
  import exe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int REG_ADDR_W = 4,
  parameter int MUL_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [3:0]            in_cond,
  input  logic                  in_set_flags,
  input  logic                  in_use_imm,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]     in_a,
  input  logic [DATA_W-1:0]     in_b,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic [DATA_W-1:0]     in_store_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_wr_en,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_br_taken,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [3:0]            flags
);

  // Logic ops and MUL refresh N and Z only; C and V carry over.
  function automatic logic [3:0] nz_update(input logic [DATA_W-1:0] res,
                                           input logic [3:0] old);
    return {res[DATA_W-1], (res == '0), old[C_BIT], old[V_BIT]};
  endfunction

  op_e                   op_in;
  logic                  accept;
  logic [DATA_W-1:0]     imm_sext;
  logic [DATA_W-1:0]     opb;

  state_e                state_q, state_d;
  logic [3:0]            flags_q, flags_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_wr_en_q, out_wr_en_d;
  logic                  out_br_q, out_br_d;
  logic [REG_ADDR_W-1:0] out_dest_q, out_dest_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;

  logic [REG_ADDR_W-1:0] dest_q;
  logic                  set_flags_q;
  logic                  we_q;
  logic [DATA_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;

  logic [DATA_W:0]       sum;
  logic [DATA_W-1:0]     alu_res;
  logic [3:0]            alu_nzcv;
  logic                  alu_flag_op;
  logic                  alu_wr_en;
  logic                  alu_br;

  logic                  mul_start;
  logic                  mul_busy;
  logic                  mul_done;
  logic [DATA_W-1:0]     mul_product;

  assign op_in    = op_e'(in_op);
  assign imm_sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign opb      = in_use_imm ? imm_sext : in_b;
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  exec_mul_iter #(
    .DATA_W(DATA_W)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .a_i      (in_a),
    .b_i      (opb),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  // Single-cycle result, flag candidate and branch decision for the op at the input.
  always_comb begin
    sum         = '0;
    alu_res     = '0;
    alu_nzcv    = flags_q;
    alu_flag_op = 1'b0;
    alu_wr_en   = 1'b1;
    alu_br      = 1'b0;
    case (op_in)
      OP_ADD: begin
        sum         = {1'b0, in_a} + {1'b0, opb};
        alu_res     = sum[DATA_W-1:0];
        alu_nzcv    = {alu_res[DATA_W-1], (alu_res == '0), sum[DATA_W],
                       (in_a[DATA_W-1] == opb[DATA_W-1]) &&
                       (alu_res[DATA_W-1] != in_a[DATA_W-1])};
        alu_flag_op = 1'b1;
      end
      OP_SUB: begin
        // A + ~B + 1: carry-out is the inverted borrow.
        sum         = {1'b0, in_a} + {1'b0, ~opb} + {{DATA_W{1'b0}}, 1'b1};
        alu_res     = sum[DATA_W-1:0];
        alu_nzcv    = {alu_res[DATA_W-1], (alu_res == '0), sum[DATA_W],
                       (in_a[DATA_W-1] != opb[DATA_W-1]) &&
                       (alu_res[DATA_W-1] != in_a[DATA_W-1])};
        alu_flag_op = 1'b1;
      end
      OP_AND: begin
        alu_res     = in_a & opb;
        alu_nzcv    = nz_update(alu_res, flags_q);
        alu_flag_op = 1'b1;
      end
      OP_ORR: begin
        alu_res     = in_a | opb;
        alu_nzcv    = nz_update(alu_res, flags_q);
        alu_flag_op = 1'b1;
      end
      OP_EOR: begin
        alu_res     = in_a ^ opb;
        alu_nzcv    = nz_update(alu_res, flags_q);
        alu_flag_op = 1'b1;
      end
      OP_MOV:  alu_res = imm_sext;
      OP_MOVT: alu_res = {in_imm, in_store_data[DATA_W-IMM_W-1:0]};
      OP_CLR:  alu_res = '0;
      OP_SET:  alu_res = '1;
      OP_LSL:  alu_res = (32'(in_imm) >= 32'(DATA_W)) ? '0 : (in_a << in_imm);
      OP_LSR:  alu_res = (32'(in_imm) >= 32'(DATA_W)) ? '0 : (in_a >> in_imm);
      OP_MOVF: alu_res = {in_a[DATA_W-1:4], flags_q};
      OP_BR: begin
        alu_res   = imm_sext;
        alu_wr_en = 1'b0;
        alu_br    = cond_pass(in_cond, flags_q);
      end
      // MUL only reaches here when the multiplier is disabled: a no-op result.
      default: alu_wr_en = 1'b0;
    endcase
  end

  // Next state, result capture and flag commit.
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !out_ready;
    out_wr_en_d = out_wr_en_q;
    out_br_d    = out_br_q;
    out_dest_d  = out_dest_q;
    out_data_d  = out_data_q;
    mul_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if ((op_in == OP_MUL) && (MUL_EN != 0)) begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else if ((op_in == OP_LD) || (op_in == OP_ST)) begin
            state_d = S_MEM_REQ;
          end else begin
            out_valid_d = 1'b1;
            out_wr_en_d = alu_wr_en;
            out_br_d    = alu_br;
            out_dest_d  = in_dest;
            out_data_d  = alu_res;
            if (in_set_flags && alu_flag_op) flags_d = alu_nzcv;
          end
        end
      end
      S_MUL: begin
        if (mul_done) begin
          out_valid_d = 1'b1;
          out_wr_en_d = 1'b1;
          out_br_d    = 1'b0;
          out_dest_d  = dest_q;
          out_data_d  = mul_product;
          if (set_flags_q) flags_d = nz_update(mul_product, flags_q);
          state_d = S_IDLE;
        end else if (!mul_busy) begin
          state_d = S_IDLE;
        end
      end
      S_MEM_REQ: begin
        if (mem_gnt) begin
          if (we_q) begin
            out_valid_d = 1'b1;
            out_wr_en_d = 1'b0;
            out_br_d    = 1'b0;
            out_dest_d  = dest_q;
            out_data_d  = '0;
            state_d     = S_IDLE;
          end else begin
            state_d = S_MEM_WAIT;
          end
        end
      end
      S_MEM_WAIT: begin
        if (mem_rvalid) begin
          out_valid_d = 1'b1;
          out_wr_en_d = 1'b1;
          out_br_d    = 1'b0;
          out_dest_d  = dest_q;
          out_data_d  = mem_rdata;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      out_wr_en_q <= 1'b0;
      out_br_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      out_wr_en_q <= out_wr_en_d;
      out_br_q    <= out_br_d;
    end
  end

  // Operand latches and result data; outputs are masked until valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      dest_q      <= in_dest;
      set_flags_q <= in_set_flags;
      we_q        <= (op_in == OP_ST);
      addr_q      <= in_a + imm_sext;
      wdata_q     <= in_store_data;
    end
    out_dest_q <= out_dest_d;
    out_data_q <= out_data_d;
  end

  assign mem_req      = (state_q == S_MEM_REQ);
  assign mem_we       = mem_req && we_q;
  assign mem_addr     = mem_req ? addr_q : '0;
  assign mem_wdata    = mem_req ? wdata_q : '0;
  assign out_valid    = out_valid_q;
  assign out_wr_en    = out_valid_q && out_wr_en_q;
  assign out_br_taken = out_valid_q && out_br_q;
  assign out_dest     = out_valid_q ? out_dest_q : '0;
  assign out_data     = out_valid_q ? out_data_q : '0;
  assign flags        = flags_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc with hand-computed expected values.
module tb_exec_unit_mc;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_cond;
  logic        in_set_flags;
  logic        in_use_imm;
  logic [3:0]  in_dest;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [15:0] in_imm;
  logic [31:0] in_store_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_wr_en;
  logic [3:0]  out_dest;
  logic [31:0] out_data;
  logic        out_br_taken;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  exec_unit_mc dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_cond      (in_cond),
    .in_set_flags (in_set_flags),
    .in_use_imm   (in_use_imm),
    .in_dest      (in_dest),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_imm       (in_imm),
    .in_store_data(in_store_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_wr_en    (out_wr_en),
    .out_dest     (out_dest),
    .out_data     (out_data),
    .out_br_taken (out_br_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .flags        (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] cond, input logic sf,
                       input logic ui, input logic [3:0] dest, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, input logic [31:0] sd);
    in_op         = op;
    in_cond       = cond;
    in_set_flags  = sf;
    in_use_imm    = ui;
    in_dest       = dest;
    in_a          = a;
    in_b          = b;
    in_imm        = imm;
    in_store_data = sd;
    in_valid      = 1'b1;
  endtask

  // Called at a falling edge with inputs driven; returns at the falling
  // edge right after the accepting rising edge, with in_valid dropped.
  task automatic accept_wait();
    int w;
    w = 0;
    #1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 200) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] cond, input logic sf,
                       input logic ui, input logic [3:0] dest, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, input logic [31:0] sd);
    drive(op, cond, sf, ui, dest, a, b, imm, sd);
    accept_wait();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  k;
    logic bad;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_cond = '0; in_set_flags = 1'b0;
    in_use_imm = 1'b0; in_dest = '0; in_a = '0; in_b = '0; in_imm = '0;
    in_store_data = '0; out_ready = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_data", out_data, 0);

    // ADD overflow, latency 1
    issue(OP_ADD, C_AL, 1, 0, 4'd3, 32'h7FFF_FFFF, 32'd1, 16'd0, 32'd0);
    chk("add_valid", out_valid, 1);
    chk("add_data", out_data, 32'h8000_0000);
    chk("add_wr_en", out_wr_en, 1);
    chk("add_dest", out_dest, 3);
    chk("add_flags", flags, 4'b1001);

    // SUB to zero, then conditional branches
    issue(OP_SUB, C_AL, 1, 1, 4'd4, 32'd5, 32'd0, 16'd5, 32'd0);
    chk("sub_data", out_data, 0);
    chk("sub_flags", flags, 4'b0110);
    issue(OP_BR, C_EQ, 0, 0, 4'd0, 32'd0, 32'd0, 16'h0010, 32'd0);
    chk("br_eq_taken", out_br_taken, 1);
    chk("br_eq_wr_en", out_wr_en, 0);
    chk("br_eq_data", out_data, 32'h10);
    issue(OP_BR, C_GT, 0, 0, 4'd0, 32'd0, 32'd0, 16'hFFF0, 32'd0);
    chk("br_gt_taken", out_br_taken, 0);
    chk("br_gt_data", out_data, 32'hFFFF_FFF0);
    chk("br_gt_valid", out_valid, 1);

    // Logic op keeps C and V
    issue(OP_ORR, C_AL, 1, 0, 4'd1, 32'h8000_0000, 32'd1, 16'd0, 32'd0);
    chk("orr_data", out_data, 32'h8000_0001);
    chk("orr_flags", flags, 4'b1010);

    // Shifts, moves, flag readback
    issue(OP_LSL, C_AL, 0, 0, 4'd2, 32'd1, 32'd0, 16'd4, 32'd0);
    chk("lsl4", out_data, 32'h10);
    issue(OP_LSL, C_AL, 0, 0, 4'd2, 32'd1, 32'd0, 16'd32, 32'd0);
    chk("lsl32", out_data, 0);
    issue(OP_LSR, C_AL, 0, 0, 4'd2, 32'h8000_0000, 32'd0, 16'd31, 32'd0);
    chk("lsr31", out_data, 1);
    issue(OP_MOVT, C_AL, 0, 0, 4'd2, 32'd0, 32'd0, 16'hABCD, 32'h1234_5678);
    chk("movt", out_data, 32'hABCD_5678);
    issue(OP_MOV, C_AL, 0, 0, 4'd2, 32'd0, 32'd0, 16'h8000, 32'd0);
    chk("mov_sext", out_data, 32'hFFFF_8000);
    issue(OP_MOVF, C_AL, 0, 0, 4'd2, 32'h1234_5678, 32'd0, 16'd0, 32'd0);
    chk("movf", out_data, 32'h1234_567A);

    // Iterative MUL latency and in_ready blocking
    drive(OP_MUL, C_AL, 0, 0, 4'd6, 32'h0000_FFFF, 32'h0001_0001, 16'd0, 32'd0);
    accept_wait();
    k = 1;
    bad = 1'b0;
    while (!out_valid && k < 60) begin
      if (in_ready) bad = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("mul_latency", k, 33);
    chk("mul_ready_low", bad, 0);
    chk("mul_data", out_data, 32'hFFFF_FFFF);
    chk("mul_dest", out_dest, 6);

    // Load with delayed grant and response
    issue(OP_LD, C_AL, 0, 0, 4'd5, 32'h100, 32'd0, 16'hFFFC, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("ld_req_wait", mem_req, 1);
      chk("ld_addr_wait", mem_addr, 32'hFC);
      @(negedge clk);
    end
    chk("ld_req", mem_req, 1);
    chk("ld_addr", mem_addr, 32'hFC);
    chk("ld_we", mem_we, 0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("ld_req_drop", mem_req, 0);
    chk("ld_no_early_valid", out_valid, 0);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("ld_valid", out_valid, 1);
    chk("ld_data", out_data, 32'hDEAD_BEEF);
    chk("ld_wr_en", out_wr_en, 1);
    chk("ld_dest", out_dest, 5);

    // Store with immediate grant
    issue(OP_ST, C_AL, 0, 0, 4'd0, 32'h200, 32'd0, 16'd8, 32'h55);
    chk("st_req", mem_req, 1);
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 32'h208);
    chk("st_wdata", mem_wdata, 32'h55);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("st_valid", out_valid, 1);
    chk("st_wr_en", out_wr_en, 0);

    // Backpressure on the output
    issue(OP_ADD, C_AL, 0, 0, 4'd7, 32'd2, 32'd3, 16'd0, 32'd0);
    out_ready = 1'b0;
    drive(OP_SUB, C_AL, 0, 0, 4'd8, 32'd9, 32'd2, 16'd0, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (in_ready || !out_valid || out_data != 32'd5 || out_dest != 4'd7) bad = 1'b1;
      @(negedge clk);
    end
    chk("stall_stable", bad, 0);
    chk("stall_data", out_data, 5);
    out_ready = 1'b1;
    #1;
    chk("release_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("release_data", out_data, 7);
    chk("release_dest", out_dest, 8);

    // Reset while waiting for load data, then a stray response
    chk("pre_rst_flags", flags, 4'b1010);
    issue(OP_LD, C_AL, 0, 0, 4'd9, 32'h40, 32'd0, 16'd0, 32'd0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("wait_req_low", mem_req, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234;
    #1;
    chk("rst_mid_req", mem_req, 0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_flags", flags, 0);
    chk("rst_mid_ready", in_ready, 1);
    @(negedge clk);
    chk("rst_mid_valid2", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
